// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use stall,
// with a sticky memory-timeout error state and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [1:0]  id_rs_use,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_wen,
  output logic        if_id_wen,
  output logic        id_ex_wen,
  output logic        ex_mem_wen,
  output logic        mem_wb_wen,
  output logic        if_id_clear,
  output logic        id_ex_clear,
  output logic        ex_mem_clear,
  output logic        mem_wb_clear,
  output logic        mem_busy,
  output logic        err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       freeze;
  logic       load_use;

  assign freeze = (state != ERR) && mem_req && !mem_ack;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs_use[0] && (id_rs1 == ex_rd)) ||
                     (id_rs_use[1] && (id_rs2 == ex_rd)));

  assign mem_busy = (state == MWAIT);
  assign err      = (state == ERR);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!pc_wen && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_nxt    = MWAIT;
          wait_cnt_nxt = '0;
        end
      end
      MWAIT: begin
        if (!freeze)
          state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST)
          state_nxt = ERR;
        else
          wait_cnt_nxt = wait_cnt + 8'd1;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // Reset forces a full flush; otherwise priority is error > freeze > branch > load-use.
  always_comb begin
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    id_ex_wen    = 1'b1;
    ex_mem_wen   = 1'b1;
    mem_wb_wen   = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_clear = 1'b0;
    if (!rstn) begin
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
      mem_wb_clear = 1'b1;
    end else if (state == ERR) begin
      pc_wen     = 1'b0;
      if_id_wen  = 1'b0;
      id_ex_wen  = 1'b0;
      ex_mem_wen = 1'b0;
      mem_wb_wen = 1'b0;
    end else if (freeze) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_clear = 1'b1;
    end else if (ex_br_taken) begin
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
    end else if (load_use) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_clear = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (timeout 4 and 255) share
// stimulus and are compared every sampled cycle against a behavioural model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [1:0]  id_rs_use;
  logic        ex_is_load, ex_br_taken, mem_req, mem_ack;

  logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic        if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
  logic        mem_busy, err;
  logic [15:0] stall_cnt;

  logic        pc_wen_s, if_id_wen_s, id_ex_wen_s, ex_mem_wen_s, mem_wb_wen_s;
  logic        if_id_clear_s, id_ex_clear_s, ex_mem_clear_s, mem_wb_clear_s;
  logic        mem_busy_s, err_s;
  logic [15:0] stall_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_use(id_rs_use),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
    .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
    .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
    .mem_busy(mem_busy), .err(err), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.MEM_TIMEOUT(255)) dut_sat (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_use(id_rs_use),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_wen(pc_wen_s), .if_id_wen(if_id_wen_s), .id_ex_wen(id_ex_wen_s),
    .ex_mem_wen(ex_mem_wen_s), .mem_wb_wen(mem_wb_wen_s),
    .if_id_clear(if_id_clear_s), .id_ex_clear(id_ex_clear_s),
    .ex_mem_clear(ex_mem_clear_s), .mem_wb_clear(mem_wb_clear_s),
    .mem_busy(mem_busy_s), .err(err_s), .stall_cnt(stall_cnt_s)
  );

  // Behavioural model: waiting on memory, cycles waited, sticky error, unbounded stall count.
  typedef struct {
    bit waiting;
    int waits;
    bit error;
    int stall;
  } model_t;

  model_t m4, m255;
  logic [26:0] obs4, exp4, obs255, exp255;

  // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb wen, if_id, id_ex, ex_mem, mem_wb clear}
  function automatic logic [8:0] model_ctrl(model_t m);
    bit hazard;
    hazard = ex_is_load && ex_rd != 0 &&
             ((id_rs_use[0] && id_rs1 == ex_rd) || (id_rs_use[1] && id_rs2 == ex_rd));
    if (!rstn)                  return 9'b11111_1111;
    if (m.error)                return 9'b00000_0000;
    if (mem_req && !mem_ack)    return 9'b00001_0001;
    if (ex_br_taken)            return 9'b11111_1100;
    if (hazard)                 return 9'b00111_0100;
    return 9'b11111_0000;
  endfunction

  function automatic logic [26:0] model_obs(model_t m);
    logic [15:0] s;
    s = (m.stall > 65535) ? 16'hFFFF : 16'(m.stall);
    return {model_ctrl(m), m.waiting, m.error, s};
  endfunction

  function automatic model_t model_next(model_t m, int tmo, logic pcw);
    bit fz;
    model_t r;
    r = m;
    if (!rstn) begin
      r.waiting = 0; r.waits = 0; r.error = 0; r.stall = 0;
      return r;
    end
    if (!pcw) r.stall++;
    fz = mem_req && !mem_ack;
    if (r.error) begin
    end else if (!r.waiting) begin
      if (fz) begin r.waiting = 1; r.waits = 0; end
    end else if (!fz) begin
      r.waiting = 0;
    end else if (r.waits == tmo - 1) begin
      r.error = 1; r.waiting = 0;
    end else begin
      r.waits++;
    end
    return r;
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] use_,
                        input logic [4:0] rd, input logic ld, input logic br,
                        input logic req, input logic ack);
    id_rs1 = rs1; id_rs2 = rs2; id_rs_use = use_; ex_rd = rd;
    ex_is_load = ld; ex_br_taken = br; mem_req = req; mem_ack = ack;
  endtask

  // Sample both DUTs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle();
    @(negedge clk);
    obs4   = {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
              if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, mem_busy, err, stall_cnt};
    obs255 = {pc_wen_s, if_id_wen_s, id_ex_wen_s, ex_mem_wen_s, mem_wb_wen_s,
              if_id_clear_s, id_ex_clear_s, ex_mem_clear_s, mem_wb_clear_s,
              mem_busy_s, err_s, stall_cnt_s};
    exp4   = model_obs(m4);
    exp255 = model_obs(m255);
    @(posedge clk);
    m4   = model_next(m4, 4, exp4[26]);
    m255 = model_next(m255, 255, exp255[26]);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_in(5'd3, 5'd3, 2'b11, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    n_checks++;
    if (obs4[26:18] !== 9'h1FF) begin
      n_fail++; $display("FAIL reset_flush: got %b expected %b", obs4[26:18], 9'h1FF);
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    cycle();
    n_checks++;
    if (obs4[17:0] !== 18'd0) begin
      n_fail++; $display("FAIL reset_state: got busy/err/stall %h expected 0", obs4[17:0]);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5'd5, 5'd9, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4 !== exp4) begin
      n_fail++; $display("FAIL load_use: got %h expected %h", obs4, exp4);
    end
    n_checks++;
    if (obs4[26:18] !== 9'b00111_0100) begin
      n_fail++; $display("FAIL load_use_ctrl: got %b expected %b", obs4[26:18], 9'b00111_0100);
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4[15:0] !== 16'd1) begin
      n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", obs4[15:0]);
    end
  endtask

  task automatic test_ex_rd_zero();
    do_reset();
    set_in(5'd0, 5'd9, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4[26:18] !== 9'b11111_0000) begin
      n_fail++; $display("FAIL rd_zero: got %b expected %b", obs4[26:18], 9'b11111_0000);
    end
  endtask

  task automatic test_branch_over_load();
    do_reset();
    set_in(5'd7, 5'd7, 2'b10, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4[26:18] !== 9'b11111_1100) begin
      n_fail++; $display("FAIL branch_flush: got %b expected %b", obs4[26:18], 9'b11111_1100);
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4[15:0] !== 16'd0) begin
      n_fail++; $display("FAIL branch_stall_cnt: got %0d expected 0", obs4[15:0]);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd1, 5'd2, 2'b11, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle();
      n_checks++;
      if (obs4 !== exp4) begin
        n_fail++; $display("FAIL mem_wait_freeze[%0d]: got %h expected %h", i, obs4, exp4);
      end
    end
    // Ack cycle: freeze lifts and load-use is evaluated in the same cycle.
    set_in(5'd1, 5'd2, 2'b11, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    n_checks++;
    if (obs4 !== exp4 || obs4[26:18] !== 9'b00111_0100 || obs4[17] !== 1'b1) begin
      n_fail++; $display("FAIL mem_wait_ack: got %h expected %h", obs4, exp4);
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4[17] !== 1'b0 || obs4[15:0] !== 16'd4) begin
      n_fail++; $display("FAIL mem_wait_return: got busy %b stall %0d expected busy 0 stall 4",
                         obs4[17], obs4[15:0]);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    n_checks++;
    if (obs4[26:18] !== 9'b11111_0000) begin
      n_fail++; $display("FAIL mem_ack_normal: got %b expected %b", obs4[26:18], 9'b11111_0000);
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs4[15:0] !== 16'd3 || obs4[17] !== 1'b0) begin
      n_fail++; $display("FAIL mem_wait_stall_cnt: got %0d expected 3", obs4[15:0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle();
      n_checks++;
      if (obs4 !== exp4) begin
        n_fail++; $display("FAIL timeout_seq[%0d]: got %h expected %h", i, obs4, exp4);
      end
    end
    // One RUN freeze cycle plus four MWAIT cycles precede ERR.
    n_checks++;
    if (obs4[26:16] !== 11'b000000000_01) begin
      n_fail++; $display("FAIL timeout_err: got %b expected %b", obs4[26:16], 11'b000000000_01);
    end
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    cycle();
    n_checks++;
    if (obs4 !== {9'b00001_0001, 2'b00, 16'd0}) begin
      n_fail++; $display("FAIL timeout_reset: got %h expected %h", obs4, {9'b00001_0001, 2'b00, 16'd0});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 59) != 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
      cycle();
      n_checks++;
      if (obs4 !== exp4) begin
        n_fail++; $display("FAIL random_t4[%0d]: got %h expected %h", i, obs4, exp4);
      end
      n_checks++;
      if (obs255 !== exp255) begin
        n_fail++; $display("FAIL random_t255[%0d]: got %h expected %h", i, obs255, exp255);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 70400; i++) begin
      set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, (i % 200 == 199));
      cycle();
      if (i % 1000 == 999) begin
        n_checks++;
        if (obs255 !== exp255) begin
          n_fail++; $display("FAIL saturation[%0d]: got %h expected %h", i, obs255, exp255);
        end
      end
    end
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if (obs255[15:0] !== 16'hFFFF || obs255[16] !== 1'b0) begin
      n_fail++; $display("FAIL saturation_final: got stall %h err %b expected FFFF err 0",
                         obs255[15:0], obs255[16]);
    end
  endtask

  initial begin
    m4   = '{0, 0, 0, 0};
    m255 = '{0, 0, 0, 0};
    rstn = 1'b0;
    set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_load_use();
    test_ex_rd_zero();
    test_branch_over_load();
    test_mem_wait();
    test_timeout();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum number of MWAIT cycles without mem_ack before the block enters ERR; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset; synchronous and active-low.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_rs_use  input  2  bit0 = rs1 read in ID; bit1 = rs2 read in ID.
REQ-006 ex_rd  input  5  destination register index of the instruction in EX.
REQ-007 ex_is_load  input  1  the instruction in EX is a load.
REQ-008 ex_br_taken  input  1  taken branch or jump resolved in EX this cycle.
REQ-009 mem_req, mem_ack  input  1 each  MEM-stage data access request; data memory completion.
REQ-010 pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  output  1 each  write enables for the PC and the four inter-stage registers.
REQ-011 if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear  output  1 each  load-zero (bubble) controls; each is effective only when the matching wen is 1.
REQ-012 mem_busy  output  1  the FSM is in MWAIT.
REQ-013 err  output  1  sticky memory timeout flag.
REQ-014 stall_cnt  output  16  count of cycles in which pc_wen = 0.

Function
REQ-015 FSM states: RUN, MWAIT, ERR; state is registered and all outputs are combinational from state and inputs.
REQ-016 Freeze condition = (state RUN or MWAIT) and mem_req = 1 and mem_ack = 0.
REQ-017 Freeze outputs: pc_wen = if_id_wen = id_ex_wen = ex_mem_wen = 0; mem_wb_wen = 1 and mem_wb_clear = 1 (bubble into WB); all other clears = 0.
REQ-018 RUN to MWAIT on freeze; MWAIT to RUN on mem_ack = 1 or mem_req = 0; MWAIT stays in MWAIT otherwise.
REQ-019 In the cycle mem_ack = 1, no freeze applies; branch and load-use rules are evaluated normally in that same cycle.
REQ-020 A wait counter (8 bit) clears on entry to MWAIT and increments each MWAIT cycle without ack.
REQ-021 When the wait counter reaches MEM_TIMEOUT-1 without ack, the FSM moves to ERR on the next edge; err = 1 from that point.
REQ-022 In ERR, all wen = 0 and all clears = 0; the FSM leaves ERR only through reset.
REQ-023 Branch flush (no freeze, ex_br_taken = 1): all wen = 1; if_id_clear = 1 and id_ex_clear = 1; ex_mem_clear = 0 and mem_wb_clear = 0.
REQ-024 Load-use hazard = ex_is_load and ex_rd != 0 and ((id_rs_use[0] and id_rs1 == ex_rd) or (id_rs_use[1] and id_rs2 == ex_rd)).
REQ-025 Load-use stall (no freeze, no branch, hazard): pc_wen = 0, if_id_wen = 0, id_ex_wen = 1, id_ex_clear = 1; EX/MEM and MEM/WB advance normally.
REQ-026 Priority: freeze > branch flush > load-use; a branch overrides load-use because the dependent instruction is squashed.
REQ-027 Normal operation (none of the above): all wen = 1 and all clears = 0.
REQ-028 stall_cnt increments on every edge where pc_wen = 0 and rstn = 1, and saturates at 0xFFFF.

Reset
REQ-029 While rstn = 0 at a rising edge: state becomes RUN, wait counter 0, err 0, stall_cnt 0.
REQ-030 While rstn = 0, outputs are forced to all wen = 1 and all clears = 1 (full pipeline flush), overriding every other rule.
REQ-031 Reset asserted in MWAIT or ERR returns to RUN with no residual freeze; a pending mem_req is re-evaluated on the first cycle after reset.

Verification
REQ-032 Load x5 in EX, ID reads rs1 = 5 with id_rs_use = 01 -> one cycle with pc_wen = 0, if_id_wen = 0, id_ex_clear = 1; stall_cnt = 1.
REQ-033 Same stimulus as REQ-032 with ex_rd = 0 -> no stall; all wen = 1.
REQ-034 ex_br_taken = 1 together with a load-use hazard -> if_id_clear = 1, id_ex_clear = 1, pc_wen = 1; stall_cnt unchanged.
REQ-035 mem_req held high, mem_ack arrives after 3 cycles -> 3 freeze cycles with mem_busy = 1 in MWAIT; mem_wb_clear = 1 during freeze; ack cycle gives normal outputs; return to RUN; stall_cnt = 3.
REQ-036 mem_req held high with no ack, MEM_TIMEOUT = 4 -> ERR entered after the 4th MWAIT cycle, err = 1, all wen = 0; rstn = 0 for one edge -> RUN, err = 0, stall_cnt = 0.
REQ-037 Run 70000 consecutive frozen cycles with MEM_TIMEOUT = 255 and periodic acks -> stall_cnt saturates at 0xFFFF and does not wrap.
